// File: rtl/piso_shift_tx.sv
// ============================================================================
// Module   : piso_shift_tx
// Brief    : Parallel-in serial-out transmit shift register with a valid/ready
//            load handshake, MSB/LSB-first order and optional circular rotate.
// Revision : 1.0
// ============================================================================
`default_nettype none

module piso_shift_tx #(
  parameter int MSB = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [MSB-1:0] din,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic           dir,
  input  logic           circular,
  input  logic           en,
  output logic           sout,
  output logic           sout_valid,
  output logic           sout_last,
  output logic           done,
  output logic [MSB-1:0] shreg_out
);

  localparam int            CW       = $clog2(MSB);
  localparam logic [CW-1:0] LAST_CNT = CW'(MSB - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state_q;
  logic [MSB-1:0] shreg_q;
  logic [MSB-1:0] shreg_d;
  logic [CW-1:0]  cnt_q;
  logic           dir_q;
  logic           circ_q;
  logic           done_q;
  logic           fill_bit;

  // The fill bit is the bit leaving the register when rotating, else zero.
  always_comb begin
    fill_bit = 1'b0;
    shreg_d  = shreg_q;
    if (dir_q) begin
      fill_bit = circ_q & shreg_q[MSB-1];
      shreg_d  = {shreg_q[MSB-2:0], fill_bit};
    end else begin
      fill_bit = circ_q & shreg_q[0];
      shreg_d  = {fill_bit, shreg_q[MSB-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      circ_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            shreg_q <= din;
            dir_q   <= dir;
            circ_q  <= circular;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (en) begin
            shreg_q <= shreg_d;
            if (cnt_q == LAST_CNT) begin
              cnt_q   <= '0;
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // sout is gated in IDLE because a rotated word remains in the register.
  assign load_ready = (state_q == IDLE);
  assign sout_valid = (state_q == SHIFT);
  assign sout       = (state_q == SHIFT) && (dir_q ? shreg_q[MSB-1] : shreg_q[0]);
  assign sout_last  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign done       = done_q;
  assign shreg_out  = shreg_q;

endmodule

`default_nettype wire

// File: tb/tb_piso_shift_tx.sv
// ============================================================================
// Module   : tb_piso_shift_tx
// Brief    : Scoreboard-driven self-checking bench for piso_shift_tx.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_piso_shift_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] din = '0;
  logic         load_valid = 1'b0;
  logic         dir = 1'b0;
  logic         circular = 1'b0;
  logic         en = 1'b0;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         sout_last;
  logic         done;
  logic [W-1:0] shreg_out;

  int   tests_run = 0;
  int   fails = 0;
  int   cyc = 0;
  logic exp_q[$];

  piso_shift_tx #(.MSB(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .din       (din),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .dir       (dir),
    .circular  (circular),
    .en        (en),
    .sout      (sout),
    .sout_valid(sout_valid),
    .sout_last (sout_last),
    .done      (done),
    .shreg_out (shreg_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Loads one word and consumes it; returns in the done cycle without ticking,
  // so a following call loads back-to-back.
  task automatic run_word(input logic [W-1:0] word, input logic d, input logic c,
                          input int stall_at, input int stall_len, input bit disturb);
    int           load_cyc;
    logic         e;
    logic [W-1:0] exp_sh;
    din        = word;
    dir        = d;
    circular   = c;
    load_valid = 1'b1;
    en         = 1'b1;
    for (int b = 0; b < W; b++) exp_q.push_back(d ? word[W-1-b] : word[b]);
    tick;
    load_cyc   = cyc;
    load_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (disturb) begin
        load_valid = (i < W - 1);
        din        = '1;
        dir        = ~dir;
        circular   = ~circular;
      end
      e = exp_q.pop_front();
      tests_run++;
      if (sout !== e || sout_valid !== 1'b1 || load_ready !== 1'b0) begin
        fails++;
        $display("FAIL word%h bit%0d: sout=%b valid=%b ready=%b, need sout=%b valid=1 ready=0",
                 word, i, sout, sout_valid, load_ready, e);
      end
      tests_run++;
      if (sout_last !== (i == W - 1)) begin
        fails++;
        $display("FAIL word%h last%0d: sout_last=%b, need %b", word, i, sout_last, (i == W - 1));
      end
      if (i == stall_at) begin
        en = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick;
          tests_run++;
          if (sout !== e || sout_valid !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL stall%0d: sout=%b valid=%b done=%b, need sout=%b valid=1 done=0",
                     s, sout, sout_valid, done, e);
          end
        end
        en = 1'b1;
      end
      tick;
    end
    exp_sh = c ? word : '0;
    tests_run++;
    if (done !== 1'b1 || load_ready !== 1'b1 || sout_valid !== 1'b0 || sout !== 1'b0) begin
      fails++;
      $display("FAIL word%h end: done=%b ready=%b valid=%b sout=%b, need 1 1 0 0",
               word, done, load_ready, sout_valid, sout);
    end
    tests_run++;
    if (shreg_out !== exp_sh) begin
      fails++;
      $display("FAIL word%h shreg: got %h, need %h", word, shreg_out, exp_sh);
    end
    tests_run++;
    if (cyc - load_cyc + 1 != W + 1 + stall_len) begin
      fails++;
      $display("FAIL word%h done_cycle: got %0d, need %0d", word, cyc - load_cyc + 1,
               W + 1 + stall_len);
    end
  endtask

  task automatic check_done_clear;
    tick;
    tests_run++;
    if (done !== 1'b0 || load_ready !== 1'b1) begin
      fails++;
      $display("FAIL done_clear: done=%b ready=%b, need 0 1", done, load_ready);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    tick;
    tick;
    tests_run++;
    if (sout !== 1'b0 || sout_valid !== 1'b0 || sout_last !== 1'b0 || done !== 1'b0 ||
        shreg_out !== '0 || load_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: sout=%b valid=%b last=%b done=%b shreg=%h ready=%b, need 0 0 0 0 00 1",
               sout, sout_valid, sout_last, done, shreg_out, load_ready);
    end
    #3 rstn = 1'b1;
    tick;
  endtask

  task automatic test_msb_first;
    run_word(8'h1E, 1'b1, 1'b0, -1, 0, 1'b0);
    check_done_clear();
  endtask

  task automatic test_lsb_first;
    run_word(8'h1E, 1'b0, 1'b0, -1, 0, 1'b0);
    check_done_clear();
  endtask

  task automatic test_stall;
    run_word(8'hA5, 1'b1, 1'b0, 1, 3, 1'b0);
    check_done_clear();
    run_word(8'h6B, 1'b0, 1'b1, 6, 2, 1'b0);
    check_done_clear();
  endtask

  task automatic test_circular;
    run_word(8'h3C, 1'b1, 1'b1, -1, 0, 1'b0);
    check_done_clear();
    run_word(8'h3C, 1'b1, 1'b0, -1, 0, 1'b0);
    check_done_clear();
    run_word(8'hC9, 1'b0, 1'b1, -1, 0, 1'b0);
    check_done_clear();
  endtask

  task automatic test_load_ignored;
    run_word(8'h96, 1'b1, 1'b0, -1, 0, 1'b1);
    check_done_clear();
    run_word(8'h5A, 1'b0, 1'b1, -1, 0, 1'b1);
    check_done_clear();
  endtask

  task automatic test_back_to_back;
    run_word(8'h3C, 1'b1, 1'b1, -1, 0, 1'b0);
    run_word(8'hA5, 1'b0, 1'b0, -1, 0, 1'b0);
    run_word(8'hF0, 1'b1, 1'b0, -1, 0, 1'b0);
    check_done_clear();
  endtask

  task automatic test_async_reset;
    din        = 8'hA5;
    dir        = 1'b1;
    circular   = 1'b1;
    load_valid = 1'b1;
    en         = 1'b1;
    tick;
    load_valid = 1'b0;
    tick;
    tick;
    tick;
    tests_run++;
    if (sout_valid !== 1'b1 || sout !== 1'b0) begin
      fails++;
      $display("FAIL pre_reset bit4: valid=%b sout=%b, need 1 0", sout_valid, sout);
    end
    #3 rstn = 1'b0;
    #1;
    tests_run++;
    if (sout !== 1'b0 || sout_valid !== 1'b0 || sout_last !== 1'b0 || done !== 1'b0 ||
        shreg_out !== '0 || load_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: sout=%b valid=%b last=%b done=%b shreg=%h ready=%b, need 0 0 0 0 00 1",
               sout, sout_valid, sout_last, done, shreg_out, load_ready);
    end
    load_valid = 1'b1;
    din        = 8'hFF;
    tick;
    tick;
    tests_run++;
    if (sout_valid !== 1'b0 || shreg_out !== '0) begin
      fails++;
      $display("FAIL reset_load_ignored: valid=%b shreg=%h, need 0 00", sout_valid, shreg_out);
    end
    load_valid = 1'b0;
    #3 rstn = 1'b1;
    tick;
    run_word(8'h81, 1'b1, 1'b0, -1, 0, 1'b0);
    check_done_clear();
    run_word(8'h81, 1'b0, 1'b1, -1, 0, 1'b0);
    check_done_clear();
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_stall();
    test_circular();
    test_load_ignored();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

`default_nettype wire
